apb_uart_regs_fifo: RTL and testbench

Second-generation APB register front end for the 16550-style UART. It adds parametrised RX/TX FIFOs, FCR-controlled FIFO clear and RX trigger level, a prioritised interrupt-identification register with sticky line-status errors, and a zero-wait APB slave with error response. It sits between the APB fabric and the UART tx/rx/baud engines.

---
 rtl/apb_uart_regs_fifo.sv | 251 +++++++++++++++++++++++++
 tb/tb_apb_uart_regs_fifo.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_uart_regs_fifo.sv
// APB register front end for a 16550-style UART with RX/TX FIFOs, FCR control,
// prioritised interrupt identification and sticky line-status errors.
module apb_uart_regs_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 3,
  parameter int unsigned DW    = 32
) (
  input  logic          PCLK,
  input  logic          PRESETn,
  input  logic [AW-1:0] PADDR,
  input  logic          PSEL,
  input  logic          PENABLE,
  input  logic          PWRITE,
  input  logic [DW-1:0] PWDATA,
  output logic [DW-1:0] PRDATA,
  output logic          PREADY,
  output logic          PSLVERR,
  input  logic          rx_push,
  input  logic [7:0]    rx_data,
  input  logic          rx_perr,
  input  logic          rx_ferr,
  input  logic          tx_pop,
  output logic [7:0]    tx_data,
  output logic          tx_empty,
  input  logic          tx_busy,
  output logic [6:0]    lcr_out,
  output logic [15:0]   divisor,
  output logic          irq
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  // Register state
  logic [7:0]    ier_q, ier_d, lcr_q, lcr_d, mcr_q, mcr_d, spr_q, spr_d;
  logic [7:0]    dll_q, dll_d, dlm_q, dlm_d;
  logic [1:0]    trig_q, trig_d;
  logic          oe_q, oe_d, pe_q, pe_d, fe_q, fe_d;
  logic          thre_q, thre_d, irq_q, irq_d;

  // FIFO state
  logic [7:0]    rx_mem_q [DEPTH];
  logic [7:0]    tx_mem_q [DEPTH];
  logic [PW-1:0] rx_wptr_q, rx_wptr_d, rx_rptr_q, rx_rptr_d;
  logic [PW-1:0] tx_wptr_q, tx_wptr_d, tx_rptr_q, tx_rptr_d;
  logic [CW-1:0] rx_cnt_q, rx_cnt_d, tx_cnt_q, tx_cnt_d;

  // Decoded access strobes
  logic          access, wr_acc, rd_acc, dlab;
  logic [2:0]    addr;
  logic          rhr_rd, thr_wr, fcr_wr, ier_wr, lsr_rd, isr_rd;
  logic          rx_full, rx_empty, tx_full, tx_empty_int;
  logic          rx_clr, tx_clr, rx_wr_en, rx_pop, tx_wr_en, tx_rd_en;
  logic [7:0]    rx_head, rdata, lsr;
  logic [3:0]    isr_id;
  logic [CW-1:0] trig_lvl;
  logic [15:0]   div_raw;
  logic [DW-9:0] unused_pwdata;

  assign addr   = PADDR[2:0];
  assign access = PSEL && PENABLE;
  assign wr_acc = access && PWRITE;
  assign rd_acc = access && !PWRITE;
  assign dlab   = lcr_q[7];

  assign rhr_rd = rd_acc && (addr == 3'd0) && !dlab;
  assign thr_wr = wr_acc && (addr == 3'd0) && !dlab;
  assign fcr_wr = wr_acc && (addr == 3'd2);
  assign ier_wr = wr_acc && (addr == 3'd1) && !dlab;
  assign lsr_rd = rd_acc && (addr == 3'd5);
  assign isr_rd = rd_acc && (addr == 3'd2);

  assign rx_full      = (rx_cnt_q == CW'(DEPTH));
  assign rx_empty     = (rx_cnt_q == '0);
  assign tx_full      = (tx_cnt_q == CW'(DEPTH));
  assign tx_empty_int = (tx_cnt_q == '0);

  // FIFO clears take priority over any push or pop in the same cycle
  assign rx_clr   = fcr_wr && PWDATA[1];
  assign tx_clr   = fcr_wr && PWDATA[2];
  assign rx_wr_en = rx_push && !rx_full && !rx_clr;
  assign rx_pop   = rhr_rd && !rx_empty;
  assign tx_wr_en = thr_wr && !tx_full && !tx_clr;
  assign tx_rd_en = tx_pop && !tx_empty_int && !tx_clr;

  assign rx_head  = rx_empty ? 8'h00 : rx_mem_q[rx_rptr_q];
  assign tx_data  = tx_empty_int ? 8'h00 : tx_mem_q[tx_rptr_q];
  assign tx_empty = tx_empty_int;

  assign PREADY  = 1'b1;
  assign PSLVERR = (thr_wr && tx_full) || (wr_acc && ((addr == 3'd5) || (addr == 3'd6)));

  assign lcr_out = lcr_q[6:0];
  assign div_raw = {dlm_q, dll_q};
  assign divisor = (div_raw == 16'd0) ? 16'd1 : div_raw;
  assign irq     = irq_q;
  assign lsr     = {1'b0, tx_empty_int && !tx_busy, tx_empty_int, 1'b0, fe_q, pe_q, oe_q,
                    !rx_empty};

  assign unused_pwdata = PWDATA[DW-1:8];

  // RX trigger threshold selected by FCR[7:6]
  always_comb begin
    trig_lvl = CW'(1);
    case (trig_q)
      2'd1:    trig_lvl = CW'(DEPTH / 4);
      2'd2:    trig_lvl = CW'(DEPTH / 2);
      2'd3:    trig_lvl = CW'(DEPTH - 2);
      default: trig_lvl = CW'(1);
    endcase
  end

  // Interrupt identification, highest priority first
  always_comb begin
    isr_id = 4'b0001;
    if (ier_q[2] && (oe_q || pe_q || fe_q))      isr_id = 4'b0110;
    else if (ier_q[0] && (rx_cnt_q >= trig_lvl)) isr_id = 4'b0100;
    else if (ier_q[1] && thre_q)                 isr_id = 4'b0010;
  end

  // Read data mux, driven only during a read access
  always_comb begin
    rdata = 8'h00;
    if (rd_acc) begin
      case (addr)
        3'd0:    rdata = dlab ? dll_q : rx_head;
        3'd1:    rdata = dlab ? dlm_q : ier_q;
        3'd2:    rdata = {4'b1100, isr_id};
        3'd3:    rdata = lcr_q;
        3'd4:    rdata = mcr_q;
        3'd5:    rdata = lsr;
        3'd6:    rdata = 8'h00;
        default: rdata = spr_q;
      endcase
    end
    PRDATA       = '0;
    PRDATA[7:0]  = rdata;
  end

  // FIFO pointer and count next state
  always_comb begin
    rx_wptr_d = rx_wptr_q;
    rx_rptr_d = rx_rptr_q;
    rx_cnt_d  = rx_cnt_q;
    tx_wptr_d = tx_wptr_q;
    tx_rptr_d = tx_rptr_q;
    tx_cnt_d  = tx_cnt_q;
    if (rx_clr) begin
      rx_wptr_d = '0;
      rx_rptr_d = '0;
      rx_cnt_d  = '0;
    end else begin
      if (rx_wr_en) rx_wptr_d = rx_wptr_q + PW'(1);
      if (rx_pop)   rx_rptr_d = rx_rptr_q + PW'(1);
      rx_cnt_d = rx_cnt_q + CW'(rx_wr_en) - CW'(rx_pop);
    end
    if (tx_clr) begin
      tx_wptr_d = '0;
      tx_rptr_d = '0;
      tx_cnt_d  = '0;
    end else begin
      if (tx_wr_en) tx_wptr_d = tx_wptr_q + PW'(1);
      if (tx_rd_en) tx_rptr_d = tx_rptr_q + PW'(1);
      tx_cnt_d = tx_cnt_q + CW'(tx_wr_en) - CW'(tx_rd_en);
    end
  end

  // Register writes, sticky line status, THRE pending and irq next state
  always_comb begin
    ier_d  = ier_q;
    lcr_d  = lcr_q;
    mcr_d  = mcr_q;
    spr_d  = spr_q;
    dll_d  = dll_q;
    dlm_d  = dlm_q;
    trig_d = trig_q;
    if (wr_acc) begin
      case (addr)
        3'd0:    if (dlab) dll_d = PWDATA[7:0];
        3'd1:    if (dlab) dlm_d = PWDATA[7:0]; else ier_d = PWDATA[7:0];
        3'd2:    trig_d = PWDATA[7:6];
        3'd3:    lcr_d = PWDATA[7:0];
        3'd4:    mcr_d = PWDATA[7:0];
        3'd7:    spr_d = PWDATA[7:0];
        default: ;
      endcase
    end
    // A new error event in the same cycle as an LSR read survives the read
    oe_d = (rx_push && rx_full) || (oe_q && !lsr_rd);
    pe_d = (rx_push && rx_perr) || (pe_q && !lsr_rd);
    fe_d = (rx_push && rx_ferr) || (fe_q && !lsr_rd);
    thre_d = thre_q;
    if ((!tx_empty_int && (tx_cnt_d == '0)) ||
        (ier_wr && PWDATA[1] && !ier_q[1] && tx_empty_int)) begin
      thre_d = 1'b1;
    end else if (thr_wr || (isr_rd && (isr_id == 4'b0010))) begin
      thre_d = 1'b0;
    end
    irq_d = !isr_id[0];
  end

  // FIFO storage, no reset needed
  always_ff @(posedge PCLK) begin
    if (rx_wr_en) rx_mem_q[rx_wptr_q] <= rx_data;
    if (tx_wr_en) tx_mem_q[tx_wptr_q] <= PWDATA[7:0];
  end

  // State registers
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      ier_q     <= '0;
      lcr_q     <= '0;
      mcr_q     <= '0;
      spr_q     <= '0;
      dll_q     <= '0;
      dlm_q     <= '0;
      trig_q    <= '0;
      oe_q      <= 1'b0;
      pe_q      <= 1'b0;
      fe_q      <= 1'b0;
      thre_q    <= 1'b0;
      irq_q     <= 1'b0;
      rx_wptr_q <= '0;
      rx_rptr_q <= '0;
      rx_cnt_q  <= '0;
      tx_wptr_q <= '0;
      tx_rptr_q <= '0;
      tx_cnt_q  <= '0;
    end else begin
      ier_q     <= ier_d;
      lcr_q     <= lcr_d;
      mcr_q     <= mcr_d;
      spr_q     <= spr_d;
      dll_q     <= dll_d;
      dlm_q     <= dlm_d;
      trig_q    <= trig_d;
      oe_q      <= oe_d;
      pe_q      <= pe_d;
      fe_q      <= fe_d;
      thre_q    <= thre_d;
      irq_q     <= irq_d;
      rx_wptr_q <= rx_wptr_d;
      rx_rptr_q <= rx_rptr_d;
      rx_cnt_q  <= rx_cnt_d;
      tx_wptr_q <= tx_wptr_d;
      tx_rptr_q <= tx_rptr_d;
      tx_cnt_q  <= tx_cnt_d;
    end
  end

endmodule

// File: tb/tb_apb_uart_regs_fifo.sv
// Self-checking bench: directed vector table and sequences plus randomized
// traffic, all compared cycle by cycle against a queue-based reference model.
module tb_apb_uart_regs_fifo;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned DW    = 32;

  logic          PCLK = 1'b0;
  logic          PRESETn = 1'b0;
  logic [2:0]    PADDR;
  logic          PSEL, PENABLE, PWRITE;
  logic [DW-1:0] PWDATA, PRDATA;
  logic          PREADY, PSLVERR;
  logic          rx_push, rx_perr, rx_ferr, tx_pop, tx_busy;
  logic [7:0]    rx_data, tx_data;
  logic          tx_empty, irq;
  logic [6:0]    lcr_out;
  logic [15:0]   divisor;

  int errors = 0;
  int checks = 0;

  always #5 PCLK = ~PCLK;

  apb_uart_regs_fifo #(.DEPTH(DEPTH), .AW(3), .DW(DW)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .rx_push(rx_push), .rx_data(rx_data), .rx_perr(rx_perr), .rx_ferr(rx_ferr),
    .tx_pop(tx_pop), .tx_data(tx_data), .tx_empty(tx_empty), .tx_busy(tx_busy),
    .lcr_out(lcr_out), .divisor(divisor), .irq(irq)
  );

  // Reference model state
  logic [7:0] rx_q[$];
  logic [7:0] tx_q[$];
  logic       m_oe, m_pe, m_fe, m_thre, m_irq;
  logic [7:0] m_ier, m_lcr, m_mcr, m_spr, m_dll, m_dlm;
  logic [1:0] m_trig;

  logic [31:0] s_prdata;
  logic        s_pslverr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    rx_q.delete();
    tx_q.delete();
    {m_oe, m_pe, m_fe, m_thre, m_irq} = '0;
    {m_ier, m_lcr, m_mcr, m_spr, m_dll, m_dlm} = '0;
    m_trig = 2'd0;
  endtask

  function automatic int trig_lvl();
    case (m_trig)
      2'd0:    return 1;
      2'd1:    return DEPTH / 4;
      2'd2:    return DEPTH / 2;
      default: return DEPTH - 2;
    endcase
  endfunction

  function automatic logic [3:0] m_isr();
    if (m_ier[2] && (m_oe || m_pe || m_fe))          return 4'b0110;
    if (m_ier[0] && (rx_q.size() >= trig_lvl()))     return 4'b0100;
    if (m_ier[1] && m_thre)                          return 4'b0010;
    return 4'b0001;
  endfunction

  function automatic logic [7:0] m_read(input logic [2:0] a, input logic [3:0] isr);
    logic e;
    e = (tx_q.size() == 0);
    case (a)
      3'd0:    return m_lcr[7] ? m_dll : ((rx_q.size() != 0) ? rx_q[0] : 8'h00);
      3'd1:    return m_lcr[7] ? m_dlm : m_ier;
      3'd2:    return {4'hC, isr};
      3'd3:    return m_lcr;
      3'd4:    return m_mcr;
      3'd5:    return {1'b0, e && !tx_busy, e, 1'b0, m_fe, m_pe, m_oe, rx_q.size() != 0};
      3'd6:    return 8'h00;
      default: return m_spr;
    endcase
  endfunction

  // Advance the model by one clock edge given this cycle's inputs
  task automatic model_update(input logic acc, input logic wr, input logic [2:0] a,
                              input logic [7:0] d, input logic [3:0] isr_now);
    logic dlab, rx_full, tx_had, tx_full, lsr_rd, thr_wr, set_t, clr_t;
    dlab    = m_lcr[7];
    m_irq   = (isr_now != 4'b0001);
    rx_full = (rx_q.size() == DEPTH);
    lsr_rd  = acc && !wr && (a == 3'd5);
    m_oe = (rx_push && rx_full) || (m_oe && !lsr_rd);
    m_pe = (rx_push && rx_perr) || (m_pe && !lsr_rd);
    m_fe = (rx_push && rx_ferr) || (m_fe && !lsr_rd);
    if (acc && !wr && (a == 3'd0) && !dlab && (rx_q.size() != 0)) void'(rx_q.pop_front());
    if (rx_push && !rx_full) rx_q.push_back(rx_data);
    thr_wr  = acc && wr && (a == 3'd0) && !dlab;
    tx_had  = (tx_q.size() != 0);
    tx_full = (tx_q.size() == DEPTH);
    if (tx_pop && tx_had) void'(tx_q.pop_front());
    if (thr_wr && !tx_full) tx_q.push_back(d);
    if (acc && wr && (a == 3'd2)) begin
      if (d[1]) rx_q.delete();
      if (d[2]) tx_q.delete();
    end
    set_t = (tx_had && (tx_q.size() == 0)) ||
            (acc && wr && (a == 3'd1) && !dlab && d[1] && !m_ier[1] && !tx_had);
    clr_t = thr_wr || (acc && !wr && (a == 3'd2) && (isr_now == 4'b0010));
    if (set_t) m_thre = 1'b1;
    else if (clr_t) m_thre = 1'b0;
    if (acc && wr) begin
      case (a)
        3'd0: if (dlab) m_dll = d;
        3'd1: if (dlab) m_dlm = d; else m_ier = d;
        3'd2: m_trig = d[7:6];
        3'd3: m_lcr = d;
        3'd4: m_mcr = d;
        3'd7: m_spr = d;
        default: ;
      endcase
    end
  endtask

  // One clock: sample outputs mid-cycle, compare against the model, then advance
  task automatic step();
    logic acc, wr;
    logic [2:0] a;
    logic [7:0] d, rv;
    logic [3:0] isr_now;
    logic [15:0] div_exp;
    acc = PSEL && PENABLE;
    wr  = PWRITE;
    a   = PADDR;
    d   = PWDATA[7:0];
    @(negedge PCLK);
    s_prdata  = PRDATA;
    s_pslverr = PSLVERR;
    isr_now = m_isr();
    rv = m_read(a, isr_now);
    div_exp = ({m_dlm, m_dll} == 16'd0) ? 16'd1 : {m_dlm, m_dll};
    chk("prdata", PRDATA, (acc && !wr) ? {24'h0, rv} : 32'h0);
    chk("pslverr", PSLVERR, 32'(acc && wr && (((a == 3'd0) && !m_lcr[7] &&
        (tx_q.size() == DEPTH)) || (a == 3'd5) || (a == 3'd6))));
    chk("pready", PREADY, 32'd1);
    chk("tx_empty", tx_empty, 32'(tx_q.size() == 0));
    if (tx_q.size() != 0) chk("tx_data", tx_data, tx_q[0]);
    chk("divisor", divisor, div_exp);
    chk("lcr_out", lcr_out, m_lcr[6:0]);
    chk("irq", irq, m_irq);
    model_update(acc, wr, a, d, isr_now);
    @(posedge PCLK);
    #1;
  endtask

  task automatic idle();
    PSEL = 0; PENABLE = 0; PWRITE = 0;
    rx_push = 0; rx_perr = 0; rx_ferr = 0; tx_pop = 0;
  endtask

  task automatic apb(input logic w, input logic [2:0] a, input logic [7:0] d,
                     output logic [31:0] rdata, output logic err);
    PSEL = 1; PENABLE = 0; PWRITE = w; PADDR = a;
    PWDATA = {24'($urandom()), d};
    step();
    PENABLE = 1;
    step();
    rdata = s_prdata;
    err   = s_pslverr;
    PSEL = 0; PENABLE = 0; PWRITE = 0;
  endtask

  task automatic apb_wr(input logic [2:0] a, input logic [7:0] d);
    logic [31:0] r;
    logic e;
    apb(1'b1, a, d, r, e);
  endtask

  task automatic apb_rd_chk(input string name, input logic [2:0] a, input logic [7:0] exp);
    logic [31:0] r;
    logic e;
    apb(1'b0, a, 8'h00, r, e);
    chk(name, r, {24'h0, exp});
  endtask

  task automatic rx_byte(input logic [7:0] b, input logic perr);
    rx_push = 1; rx_data = b; rx_perr = perr;
    step();
    rx_push = 0; rx_perr = 0;
  endtask

  typedef struct {
    logic       wr;
    logic [2:0] addr;
    logic [7:0] data;
    logic [7:0] exp;
  } vec_t;

  localparam int NVEC = 16;
  vec_t vecs[NVEC];

  initial begin
    logic [31:0] r;
    logic        e;

    // Reset-state reads, then divisor latch programming
    vecs[0]  = '{1'b0, 3'd0, 8'h00, 8'h00};
    vecs[1]  = '{1'b0, 3'd1, 8'h00, 8'h00};
    vecs[2]  = '{1'b0, 3'd2, 8'h00, 8'hC1};
    vecs[3]  = '{1'b0, 3'd3, 8'h00, 8'h00};
    vecs[4]  = '{1'b0, 3'd4, 8'h00, 8'h00};
    vecs[5]  = '{1'b0, 3'd5, 8'h00, 8'h60};
    vecs[6]  = '{1'b0, 3'd6, 8'h00, 8'h00};
    vecs[7]  = '{1'b0, 3'd7, 8'h00, 8'h00};
    vecs[8]  = '{1'b1, 3'd3, 8'h83, 8'h00};
    vecs[9]  = '{1'b1, 3'd0, 8'h1B, 8'h00};
    vecs[10] = '{1'b1, 3'd1, 8'h00, 8'h00};
    vecs[11] = '{1'b0, 3'd0, 8'h00, 8'h1B};
    vecs[12] = '{1'b0, 3'd1, 8'h00, 8'h00};
    vecs[13] = '{1'b1, 3'd3, 8'h03, 8'h00};
    vecs[14] = '{1'b0, 3'd3, 8'h00, 8'h03};
    vecs[15] = '{1'b0, 3'd0, 8'h00, 8'h00};

    idle();
    PADDR = 0; PWDATA = 0; rx_data = 0; tx_busy = 0;
    model_reset();
    #22 PRESETn = 1'b1;
    @(posedge PCLK);
    #1;
    chk("rst_divisor", divisor, 32'd1);
    chk("rst_irq", irq, 32'd0);
    chk("rst_tx_empty", tx_empty, 32'd1);

    for (int i = 0; i < NVEC; i++) begin
      if (vecs[i].wr) apb_wr(vecs[i].addr, vecs[i].data);
      else apb_rd_chk($sformatf("vec%0d", i), vecs[i].addr, vecs[i].exp);
    end
    chk("div27", divisor, 32'd27);
    chk("lcr_out3", lcr_out, 32'h03);

    // RX overflow and drain
    for (int i = 0; i <= 16; i++) rx_byte(8'(i), 1'b0);
    apb_rd_chk("lsr_ovf", 3'd5, 8'h63);
    for (int i = 0; i < 16; i++) begin
      apb_rd_chk("rhr_seq", 3'd0, 8'(i));
      if (i == 0) apb_rd_chk("lsr_oe_clr", 3'd5, 8'h61);
    end
    apb_rd_chk("rhr_empty", 3'd0, 8'h00);
    apb_rd_chk("lsr_idle", 3'd5, 8'h60);

    // RX trigger level DEPTH/2
    apb_wr(3'd2, 8'h80);
    apb_wr(3'd1, 8'h01);
    for (int i = 0; i < 7; i++) rx_byte(8'hA0 + 8'(i), 1'b0);
    step();
    chk("irq_below_trig", irq, 32'd0);
    rx_byte(8'hA7, 1'b0);
    chk("irq_latency", irq, 32'd0);
    step();
    chk("irq_trig", irq, 32'd1);
    apb_rd_chk("isr_trig", 3'd2, 8'hC4);
    apb_rd_chk("rhr_trig", 3'd0, 8'hA0);
    step();
    chk("irq_trig_drop", irq, 32'd0);
    apb_wr(3'd2, 8'h02);
    apb_wr(3'd1, 8'h00);

    // THRE interrupt and TX full error
    apb_wr(3'd1, 8'h02);
    step();
    chk("irq_thre", irq, 32'd1);
    apb_rd_chk("isr_thre", 3'd2, 8'hC2);
    step();
    chk("irq_thre_drop", irq, 32'd0);
    for (int i = 0; i < 16; i++) begin
      apb(1'b1, 3'd0, 8'h30 + 8'(i), r, e);
      chk("thr_ok", 32'(e), 32'd0);
    end
    apb(1'b1, 3'd0, 8'hEE, r, e);
    chk("thr_full_err", 32'(e), 32'd1);
    tx_pop = 1;
    for (int i = 0; i < 16; i++) step();
    tx_pop = 0;
    apb_rd_chk("isr_thre_again", 3'd2, 8'hC2);
    apb_wr(3'd1, 8'h00);

    // Line status outranks data-ready
    apb_wr(3'd2, 8'h06);
    apb_wr(3'd0, 8'h55);
    apb_wr(3'd1, 8'h05);
    for (int i = 0; i < 4; i++) rx_byte(8'h10 + 8'(i), 1'b0);
    rx_byte(8'h99, 1'b1);
    apb_rd_chk("isr_ls", 3'd2, 8'hC6);
    apb_rd_chk("lsr_pe", 3'd5, 8'h05);
    apb_rd_chk("isr_data", 3'd2, 8'hC4);
    apb_wr(3'd2, 8'h02);
    apb_rd_chk("lsr_dr_clr", 3'd5, 8'h00);
    apb_wr(3'd2, 8'h06);
    apb_wr(3'd1, 8'h00);

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      PSEL    = ($urandom_range(0, 3) != 0);
      PENABLE = $urandom_range(0, 1);
      PWRITE  = $urandom_range(0, 1);
      PADDR   = 3'($urandom_range(0, 7));
      PWDATA  = $urandom();
      if (PWRITE && (PADDR == 3'd2) && ($urandom_range(0, 7) != 0)) PWDATA[2:1] = 2'b00;
      if (PWRITE && (PADDR == 3'd3) && ($urandom_range(0, 3) != 0)) PWDATA[7] = 1'b0;
      rx_push = ($urandom_range(0, 2) == 0);
      rx_data = 8'($urandom());
      rx_perr = ($urandom_range(0, 15) == 0);
      rx_ferr = ($urandom_range(0, 15) == 0);
      tx_pop  = ($urandom_range(0, 15) == 0);
      tx_busy = $urandom_range(0, 1);
      // Keep push-into-full and pop from landing on the same cycle
      if (PSEL && PENABLE && !PWRITE && (PADDR == 3'd0) && !m_lcr[7] && (rx_q.size() == DEPTH))
        rx_push = 0;
      if (PSEL && PENABLE && PWRITE && (PADDR == 3'd0) && !m_lcr[7] && (tx_q.size() == DEPTH))
        tx_pop = 0;
      step();
    end

    // Asynchronous reset mid-cycle
    idle();
    tx_busy = 0;
    apb_wr(3'd3, 8'h80);
    apb_wr(3'd0, 8'h05);
    apb_wr(3'd3, 8'h00);
    apb_wr(3'd0, 8'h42);
    #2 PRESETn = 1'b0;
    #1;
    chk("arst_tx_empty", tx_empty, 32'd1);
    chk("arst_divisor", divisor, 32'd1);
    chk("arst_irq", irq, 32'd0);
    model_reset();
    @(negedge PCLK);
    PRESETn = 1'b1;
    @(posedge PCLK);
    #1;
    apb_rd_chk("lsr_post_rst", 3'd5, 8'h60);
    apb_rd_chk("isr_post_rst", 3'd2, 8'hC1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
